// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode encodings, flag bit positions and the signed-overflow rule.
// The shift operations are only implemented when ALU_SHIFT_EN is defined (see alu.sv).
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_OP_ADD  = 3'd0;
  localparam logic [2:0] ALU_OP_SUB  = 3'd1;
  localparam logic [2:0] ALU_OP_AND  = 3'd2;
  localparam logic [2:0] ALU_OP_OR   = 3'd3;
  localparam logic [2:0] ALU_OP_LESS = 3'd4;
  localparam logic [2:0] ALU_OP_B    = 3'd5;
  localparam logic [2:0] ALU_OP_SLL  = 3'd6;
  localparam logic [2:0] ALU_OP_SRL  = 3'd7;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_ZERO = 1;

  // Overflow occurs when the effective operands share a sign and the result sign differs.
  // The caller passes the sign of y as it is actually added, i.e. inverted when subtracting.
  function automatic logic signed_ovf(input logic a_sign, input logic b_eff_sign,
                                      input logic r_sign);
    return (a_sign == b_eff_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared 32-bit adder/subtractor with signed-overflow detection.
// Used for ADD, SUB and the signed comparison behind LESS.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  logic [DATA_W-1:0] b_eff;

  // Subtraction as a + ~b + 1 keeps a single carry chain for both operations.
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(DATA_W-1){1'b0}}, sub};
  assign ovf   = signed_ovf(a[DATA_W-1], b_eff[DATA_W-1], sum[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// Combinational 32-bit ALU with a registered flag word.
// Define ALU_SHIFT_EN to implement SLL/SRL; otherwise those opcodes return zero.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [2:0]        ALUOp,
  input  logic [5:0]        shamt,
  input  logic [DATA_W-1:0] Flag,
  input  logic              FlagWE,
  output logic [DATA_W-1:0] ALUOut,
  output logic [DATA_W-1:0] NFlag,
  output logic [DATA_W-1:0] FlagReg
);

  logic              sub_sel;
  logic [DATA_W-1:0] sum;
  logic              add_ovf;
  logic              less;
  logic [DATA_W-1:0] sll_res;
  logic [DATA_W-1:0] srl_res;

  // Only ADD adds; SUB and LESS both need x - y.
  assign sub_sel = (ALUOp != ALU_OP_ADD);

  alu_addsub u_addsub (
    .a   (x),
    .b   (y),
    .sub (sub_sel),
    .sum (sum),
    .ovf (add_ovf)
  );

  // Signed x < y: the sign of x - y is wrong exactly when the subtraction overflowed.
  assign less = sum[DATA_W-1] ^ add_ovf;

`ifdef ALU_SHIFT_EN
  assign sll_res = shamt[5] ? '0 : (y << shamt[4:0]);
  assign srl_res = shamt[5] ? '0 : (y >> shamt[4:0]);
`else
  logic unused_shamt;
  assign unused_shamt = ^shamt;
  assign sll_res      = '0;
  assign srl_res      = '0;
`endif

  always_comb begin
    ALUOut = '0;
    case (ALUOp)
      ALU_OP_ADD:  ALUOut = sum;
      ALU_OP_SUB:  ALUOut = sum;
      ALU_OP_AND:  ALUOut = x & y;
      ALU_OP_OR:   ALUOut = x | y;
      ALU_OP_LESS: ALUOut = {{(DATA_W-1){1'b0}}, less};
      ALU_OP_B:    ALUOut = y;
      ALU_OP_SLL:  ALUOut = sll_res;
      ALU_OP_SRL:  ALUOut = srl_res;
      default:     ALUOut = '0;
    endcase
  end

  always_comb begin
    NFlag            = Flag;
    NFlag[FLAG_OVF]  = add_ovf && ((ALUOp == ALU_OP_ADD) || (ALUOp == ALU_OP_SUB));
    NFlag[FLAG_ZERO] = (ALUOut == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlagReg <= '0;
    end else if (FlagWE) begin
      FlagReg <= NFlag;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model of the ALU and flag register.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] x, y, Flag;
  logic [2:0]  ALUOp;
  logic [5:0]  shamt;
  logic        FlagWE;
  logic [31:0] ALUOut, NFlag, FlagReg;

  int          n_vec = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] mflag = 32'h0;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (x),
    .y       (y),
    .ALUOp   (ALUOp),
    .shamt   (shamt),
    .Flag    (Flag),
    .FlagWE  (FlagWE),
    .ALUOut  (ALUOut),
    .NFlag   (NFlag),
    .FlagReg (FlagReg)
  );

  always #5 clk = ~clk;

  // Reference model: returns {nflag, result} computed with plain signed arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [5:0] sh,
                                        input logic [31:0] f);
    longint      wide;
    logic [31:0] r;
    logic        ov;
    r    = 32'h0;
    ov   = 1'b0;
    wide = 0;
    case (op)
      3'd0: begin
        wide = longint'($signed(a)) + longint'($signed(b));
        r    = a + b;
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'd1: begin
        wide = longint'($signed(a)) - longint'($signed(b));
        r    = a - b;
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: r = b;
`ifdef ALU_SHIFT_EN
      3'd6: r = (sh >= 6'd32) ? 32'h0 : (b << sh);
      3'd7: r = (sh >= 6'd32) ? 32'h0 : (b >> sh);
`else
      3'd6: r = 32'h0;
      3'd7: r = 32'h0;
`endif
      default: r = 32'h0;
    endcase
    return {f[31:2], (r == 32'h0), ov, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] sh, input logic [31:0] f, input logic we);
    @(posedge clk);
    #1;
    ALUOp  = op;
    x      = a;
    y      = b;
    shamt  = sh;
    Flag   = f;
    FlagWE = we;
  endtask

  task automatic expect_lit(input string name, input logic [31:0] out, input logic [31:0] nf);
    #1;
    check({name, "_out"}, ALUOut, out);
    check({name, "_nflag"}, NFlag, nf);
    $display("vec %-10s op=%0d x=%h y=%h sh=%0d -> out=%h nflag=%h", name, ALUOp, x, y,
             shamt, ALUOut, NFlag);
  endtask

  // Flag register as the specification describes it: async clear, load on enabled edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mflag <= 32'h0;
    else if (FlagWE) mflag <= model(ALUOp, x, y, shamt, Flag)[63:32];
  end

  // Every cycle, away from the active edge, compare the whole DUT state with the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] m;
      m = model(ALUOp, x, y, shamt, Flag);
      check("cyc_out", ALUOut, m[31:0]);
      check("cyc_nflag", NFlag, m[63:32]);
      check("cyc_flagreg", FlagReg, mflag);
    end
  end

  initial begin
    logic [31:0] held_out;
    logic [31:0] edge_vals [6];
    edge_vals = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff, 32'h12345678};

    rst_n  = 1'b0;
    ALUOp  = 3'd0;
    x      = 32'h0;
    y      = 32'h0;
    shamt  = 6'd0;
    Flag   = 32'h0;
    FlagWE = 1'b1;
    #1;
    check("reset_flagreg", FlagReg, 32'h0);
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    apply(3'd1, 32'd300, 32'd300, 6'd0, 32'h0, 1'b0);
    expect_lit("sub_zero", 32'h0, 32'h2);
    apply(3'd0, 32'h7fffffff, 32'd1, 6'd0, 32'h0, 1'b0);
    expect_lit("add_ovf", 32'h80000000, 32'h1);
    apply(3'd0, 32'd100, 32'd200, 6'd0, 32'h0, 1'b0);
    expect_lit("add", 32'd300, 32'h0);
    apply(3'd1, 32'h70000000, 32'h90000000, 6'd0, 32'h0, 1'b0);
    expect_lit("sub_ovf", 32'he0000000, 32'h1);
    apply(3'd1, 32'd100, 32'd200, 6'd0, 32'h0, 1'b0);
    expect_lit("sub_neg", 32'hffffff9c, 32'h0);
    apply(3'd2, 32'd100, 32'd200, 6'd0, 32'h0, 1'b0);
    expect_lit("and", 32'd64, 32'h0);
    apply(3'd3, 32'd100, 32'd200, 6'd0, 32'h0, 1'b0);
    expect_lit("or", 32'd236, 32'h0);
    apply(3'd4, 32'd100, 32'd200, 6'd0, 32'h0, 1'b0);
    expect_lit("less", 32'd1, 32'h0);
    apply(3'd4, 32'h80000000, 32'h7fffffff, 6'd0, 32'h0, 1'b0);
    expect_lit("less_sgn", 32'd1, 32'h0);
    apply(3'd4, 32'h7fffffff, 32'h80000000, 6'd0, 32'h0, 1'b0);
    expect_lit("less_no", 32'd0, 32'h2);
    apply(3'd5, 32'd100, 32'd200, 6'd0, 32'h0, 1'b0);
    expect_lit("pass_b", 32'd200, 32'h0);
    apply(3'd0, 32'd1, 32'd1, 6'd0, 32'habcd0003, 1'b0);
    expect_lit("flag_keep", 32'd2, 32'habcd0000);
`ifdef ALU_SHIFT_EN
    apply(3'd6, 32'h0, 32'd1, 6'd31, 32'h0, 1'b0);
    expect_lit("sll31", 32'h80000000, 32'h0);
    apply(3'd7, 32'h0, 32'h80000000, 6'd32, 32'h0, 1'b0);
    expect_lit("srl32", 32'h0, 32'h2);
    apply(3'd7, 32'h0, 32'h80000000, 6'd4, 32'h0, 1'b0);
    expect_lit("srl4", 32'h08000000, 32'h0);
`else
    apply(3'd6, 32'h0, 32'd1, 6'd31, 32'h0, 1'b0);
    expect_lit("sll_off", 32'h0, 32'h2);
    apply(3'd7, 32'hffffffff, 32'hffffffff, 6'd0, 32'h0, 1'b0);
    expect_lit("srl_off", 32'h0, 32'h2);
`endif

    // Flag register load, then asynchronous clear mid-cycle.
    apply(3'd0, 32'h7fffffff, 32'd1, 6'd0, 32'hf0000000, 1'b1);
    @(posedge clk);
    #1;
    FlagWE = 1'b0;
    #1;
    check("flagreg_load", FlagReg, 32'hf0000001);
    held_out = 32'h80000000;
    rst_n = 1'b0;
    #1;
    check("flagreg_async_clr", FlagReg, 32'h0);
    check("aluout_in_reset", ALUOut, held_out);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("flagreg_hold", FlagReg, 32'h0);
    $display("vec flagreg   load/clear/hold sequence done");

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = (i % 3 == 0) ? edge_vals[$urandom_range(5)] : $urandom;
      b = (i % 4 == 0) ? edge_vals[$urandom_range(5)] : $urandom;
      apply(3'($urandom_range(7)), a, b, 6'($urandom_range(40)), $urandom,
            1'($urandom_range(1)));
      #1;
      $display("vec rand%0d op=%0d x=%h y=%h sh=%0d -> out=%h nflag=%h flagreg=%h", i, ALUOp,
               x, y, shamt, ALUOut, NFlag, FlagReg);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
